// File: rtl/tone_sequencer_pkg.sv
// Shared types and helpers for the tone sequencer: FSM state encoding,
// default beat prescale and counter-width helper.
package tone_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_t;

    // 1 ms per beat at a 12 MHz system clock
    localparam int unsigned BEAT_DIV_DEFAULT = 12000;

    // Counter width for a modulus of n; never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tone_sequencer_note_fifo.sv
// Show-ahead note queue with occupancy count; the ready flag is registered
// alongside the count so the producer sees a clean not-full indication.
module tone_sequencer_note_fifo
    import tone_sequencer_pkg::*;
#(
    parameter  int unsigned WIDTH = 28,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ready
);

    localparam int unsigned    PTR_W    = cnt_w(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ready;
    logic [CNT_W-1:0] w_count_next;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_push = i_push && r_ready;
    assign w_pop  = i_pop && (r_count != '0);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= w_count_next;
            r_ready <= (w_count_next != CNT_W'(DEPTH));
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_ready = r_ready;

endmodule

// File: rtl/tone_sequencer.sv
// Note scheduler: plays queued (period, duration) notes as sine-step strobes,
// with an optional silent gap between notes; the sine block is held in reset when silent.
module tone_sequencer
    import tone_sequencer_pkg::*;
#(
    parameter  int unsigned DIV_W     = 16,
    parameter  int unsigned DUR_W     = 12,
    parameter  int unsigned DEPTH     = 4,
    parameter  int unsigned BEAT_DIV  = BEAT_DIV_DEFAULT,
    parameter  int unsigned GAP_BEATS = 10,
    localparam int unsigned LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_note_valid,
    output logic             o_note_ready,
    input  logic [DIV_W-1:0] i_note_div,
    input  logic [DUR_W-1:0] i_note_dur,
    input  logic             i_start,
    input  logic             i_stop,
    output logic             o_sin_clk,
    output logic             o_sine_reset,
    output logic             o_busy,
    output logic             o_playing,
    output logic             o_underrun,
    output logic [LVL_W-1:0] o_fifo_level
);

    localparam int unsigned      PRE_W    = cnt_w(BEAT_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BEAT_DIV - 1);
    localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'((GAP_BEATS == 0) ? 0 : GAP_BEATS - 1);

    seq_state_t             r_state, w_state_next;
    logic [DIV_W-1:0]       r_div, w_div_next;
    logic [DIV_W-1:0]       r_phase, w_phase_next;
    logic [DUR_W-1:0]       r_dur, w_dur_next;
    logic [DUR_W-1:0]       r_beat, w_beat_next;
    logic [PRE_W-1:0]       r_pre, w_pre_next;
    logic                   r_sin_clk, r_sine_reset, r_busy, r_playing, r_underrun;
    logic                   w_sin_clk_next, w_underrun_next, w_note_done, w_pop;
    logic [DIV_W+DUR_W-1:0] w_head;
    logic [LVL_W-1:0]       w_level;
    logic [DUR_W-1:0]       w_dur_last;
    logic                   w_beat_wrap;

    tone_sequencer_note_fifo #(
        .WIDTH (DIV_W + DUR_W),
        .DEPTH (DEPTH)
    ) u_note_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_note_valid),
        .i_data  ({i_note_div, i_note_dur}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_level),
        .o_ready (o_note_ready)
    );

    // A zero duration plays for one beat
    assign w_dur_last  = (r_dur == '0) ? '0 : r_dur - DUR_W'(1);
    assign w_beat_wrap = (r_pre == PRE_LAST);

    always_comb begin
        w_state_next    = r_state;
        w_div_next      = r_div;
        w_dur_next      = r_dur;
        w_phase_next    = r_phase;
        w_pre_next      = r_pre;
        w_beat_next     = r_beat;
        w_pop           = 1'b0;
        w_note_done     = 1'b0;
        w_underrun_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start && (w_level != '0)) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_pop        = 1'b1;
                w_div_next   = w_head[DIV_W+DUR_W-1:DUR_W];
                w_dur_next   = w_head[DUR_W-1:0];
                w_phase_next = '0;
                w_pre_next   = '0;
                w_beat_next  = '0;
                w_state_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (r_div != '0) begin
                    w_phase_next = (r_phase == r_div - DIV_W'(1)) ? '0 : r_phase + DIV_W'(1);
                end
                w_pre_next = w_beat_wrap ? '0 : r_pre + PRE_W'(1);
                if (w_beat_wrap) begin
                    if (r_beat == w_dur_last) begin
                        w_beat_next = '0;
                        if (GAP_BEATS != 0) w_state_next = ST_GAP;
                        else                w_note_done  = 1'b1;
                    end else begin
                        w_beat_next = r_beat + DUR_W'(1);
                    end
                end
            end
            ST_GAP: begin
                w_pre_next = w_beat_wrap ? '0 : r_pre + PRE_W'(1);
                if (w_beat_wrap) begin
                    if (r_beat == GAP_LAST) begin
                        w_beat_next = '0;
                        w_note_done = 1'b1;
                    end else begin
                        w_beat_next = r_beat + DUR_W'(1);
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_note_done) begin
            if (w_level != '0) begin
                w_state_next = ST_LOAD;
            end else begin
                w_state_next    = ST_IDLE;
                w_underrun_next = 1'b1;
            end
        end

        // stop aborts from any state and leaves the queue untouched
        if (i_stop) begin
            w_state_next    = ST_IDLE;
            w_pop           = 1'b0;
            w_underrun_next = 1'b0;
        end

        w_sin_clk_next = (w_state_next == ST_PLAY) && (w_div_next != '0) &&
                         (w_phase_next == w_div_next - DIV_W'(1));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_div        <= '0;
            r_dur        <= '0;
            r_phase      <= '0;
            r_pre        <= '0;
            r_beat       <= '0;
            r_sin_clk    <= 1'b0;
            r_sine_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_playing    <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_div        <= w_div_next;
            r_dur        <= w_dur_next;
            r_phase      <= w_phase_next;
            r_pre        <= w_pre_next;
            r_beat       <= w_beat_next;
            r_sin_clk    <= w_sin_clk_next;
            r_sine_reset <= (w_state_next != ST_PLAY);
            r_busy       <= (w_state_next != ST_IDLE);
            r_playing    <= (w_state_next == ST_PLAY);
            r_underrun   <= w_underrun_next;
        end
    end

    assign o_sin_clk    = r_sin_clk;
    assign o_sine_reset = r_sine_reset;
    assign o_busy       = r_busy;
    assign o_playing    = r_playing;
    assign o_underrun   = r_underrun;
    assign o_fifo_level = w_level;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: two instances (gap of 2 beats and no gap) with
// BEAT_DIV=4; strobe/underrun events are checked against a timestamped scoreboard.
module tb_tone_sequencer;

    typedef struct {
        int kind;   // 0 = sin_clk strobe, 1 = underrun pulse
        int cyc;
    } ev_t;

    logic        clk;
    logic        reset;
    logic        note_valid [2];
    logic [15:0] note_div   [2];
    logic [11:0] note_dur   [2];
    logic        start      [2];
    logic        stop       [2];
    logic        note_ready [2];
    logic        sin_clk    [2];
    logic        sine_reset [2];
    logic        busy       [2];
    logic        playing    [2];
    logic        underrun   [2];
    logic [2:0]  fifo_level [2];

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    ev_t exp_a[$];
    ev_t exp_b[$];

    tone_sequencer #(
        .DIV_W(16), .DUR_W(12), .DEPTH(4), .BEAT_DIV(4), .GAP_BEATS(2)
    ) dut_a (
        .i_clk(clk), .i_reset(reset),
        .i_note_valid(note_valid[0]), .o_note_ready(note_ready[0]),
        .i_note_div(note_div[0]), .i_note_dur(note_dur[0]),
        .i_start(start[0]), .i_stop(stop[0]),
        .o_sin_clk(sin_clk[0]), .o_sine_reset(sine_reset[0]),
        .o_busy(busy[0]), .o_playing(playing[0]),
        .o_underrun(underrun[0]), .o_fifo_level(fifo_level[0])
    );

    tone_sequencer #(
        .DIV_W(16), .DUR_W(12), .DEPTH(4), .BEAT_DIV(4), .GAP_BEATS(0)
    ) dut_b (
        .i_clk(clk), .i_reset(reset),
        .i_note_valid(note_valid[1]), .o_note_ready(note_ready[1]),
        .i_note_div(note_div[1]), .i_note_dur(note_dur[1]),
        .i_start(start[1]), .i_stop(stop[1]),
        .o_sin_clk(sin_clk[1]), .o_sine_reset(sine_reset[1]),
        .o_busy(busy[1]), .o_playing(playing[1]),
        .o_underrun(underrun[1]), .o_fifo_level(fifo_level[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic exp_ev(input int d, input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        if (d == 0) exp_a.push_back(e);
        else        exp_b.push_back(e);
    endtask

    // Monitor side of the scoreboard
    task automatic sb_check(input int d, input int kind);
        ev_t e;
        int  sz;
        sz = (d == 0) ? exp_a.size() : exp_b.size();
        if (sz == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected dut%0d kind %0d @cyc %0d: got event, expected none", d, kind, cyc);
        end else begin
            e = (d == 0) ? exp_a.pop_front() : exp_b.pop_front();
            chk($sformatf("sb_kind_dut%0d", d), kind, e.kind);
            chk($sformatf("sb_cyc_dut%0d", d), cyc, e.cyc);
            if (kind == 0) chk($sformatf("strobe_sine_reset_dut%0d", d), 32'(sine_reset[d]), 0);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int d = 0; d < 2; d++) begin
                if (sin_clk[d] === 1'b1)  sb_check(d, 0);
                if (underrun[d] === 1'b1) sb_check(d, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            note_valid[d] = 1'b0;
            note_div[d]   = '0;
            note_dur[d]   = '0;
            start[d]      = 1'b0;
            stop[d]       = 1'b0;
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic push_note(input int d, input int div, input int dur);
        int n;
        note_valid[d] = 1'b1;
        note_div[d]   = 16'(div);
        note_dur[d]   = 12'(dur);
        n = 0;
        while (note_ready[d] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout dut%0d: note_ready got 0, expected 1", d);
        end else begin
            tick();
        end
        note_valid[d] = 1'b0;
    endtask

    // Single note on instance 0 followed by gap and underrun
    task automatic play_one(input int div, input int dur);
        int s, len, gap, lvl;
        len = ((dur == 0) ? 1 : dur) * 4;
        gap = 2 * 4;
        push_note(0, div, dur);
        lvl = 32'(fifo_level[0]);
        chk("queued_level", lvl, 1);
        start[0] = 1'b1;
        s = cyc;
        if (div != 0) begin
            for (int k = div; k <= len; k += div) exp_ev(0, 0, s + 1 + k);
        end
        exp_ev(0, 1, s + 2 + len + gap);
        tick();
        start[0] = 1'b0;
        for (int c = s + 1; c <= s + 2 + len + gap; c++) begin
            chk("play_playing", 32'(playing[0]), 32'((c >= s + 2) && (c <= s + 1 + len)));
            chk("play_sine_reset", 32'(sine_reset[0]), 32'(!((c >= s + 2) && (c <= s + 1 + len))));
            chk("play_busy", 32'(busy[0]), 32'(c <= s + 1 + len + gap));
            tick();
        end
    endtask

    initial begin
        int s;
        do_reset();

        // Reset state
        for (int d = 0; d < 2; d++) begin
            chk("rst_note_ready", 32'(note_ready[d]), 1);
            chk("rst_busy", 32'(busy[d]), 0);
            chk("rst_playing", 32'(playing[d]), 0);
            chk("rst_sine_reset", 32'(sine_reset[d]), 1);
            chk("rst_sin_clk", 32'(sin_clk[d]), 0);
            chk("rst_fifo_level", 32'(fifo_level[d]), 0);
        end

        // div=3, dur=2 note, then a rest
        play_one(3, 2);
        play_one(0, 1);

        // Full queue: fifth push held until the first pop
        for (int i = 0; i < 4; i++) push_note(0, 0, 1);
        chk("full_ready", 32'(note_ready[0]), 0);
        chk("full_level", 32'(fifo_level[0]), 4);
        note_valid[0] = 1'b1;
        note_div[0]   = 16'd0;
        note_dur[0]   = 12'd1;
        start[0]      = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("load_level", 32'(fifo_level[0]), 4);
        chk("load_ready", 32'(note_ready[0]), 0);
        chk("load_busy", 32'(busy[0]), 1);
        tick();
        chk("after_pop_level", 32'(fifo_level[0]), 3);
        chk("after_pop_ready", 32'(note_ready[0]), 1);
        tick();
        note_valid[0] = 1'b0;
        chk("held_push_level", 32'(fifo_level[0]), 4);
        chk("held_push_ready", 32'(note_ready[0]), 0);
        chk("held_push_playing", 32'(playing[0]), 1);
        do_reset();
        chk("reset_discard_level", 32'(fifo_level[0]), 0);

        // stop on the second PLAY cycle of a 3-note queue
        for (int i = 0; i < 3; i++) push_note(0, 2, 2);
        start[0] = 1'b1;
        s = cyc;
        exp_ev(0, 0, s + 3);
        tick();
        start[0] = 1'b0;
        tick();
        chk("stop_pre_playing", 32'(playing[0]), 1);
        tick();
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        chk("stop_playing", 32'(playing[0]), 0);
        chk("stop_busy", 32'(busy[0]), 0);
        chk("stop_sine_reset", 32'(sine_reset[0]), 1);
        chk("stop_level", 32'(fifo_level[0]), 2);
        start[0] = 1'b1;
        stop[0]  = 1'b1;
        tick();
        start[0] = 1'b0;
        stop[0]  = 1'b0;
        chk("start_stop_busy", 32'(busy[0]), 0);
        chk("start_stop_level", 32'(fifo_level[0]), 2);
        tick();
        chk("start_stop_busy2", 32'(busy[0]), 0);
        do_reset();

        // No-gap instance: two div=1 notes back to back
        push_note(1, 1, 1);
        push_note(1, 1, 1);
        start[1] = 1'b1;
        s = cyc;
        for (int c = s + 2; c <= s + 5; c++)  exp_ev(1, 0, c);
        for (int c = s + 7; c <= s + 10; c++) exp_ev(1, 0, c);
        exp_ev(1, 1, s + 11);
        tick();
        start[1] = 1'b0;
        for (int c = s + 1; c <= s + 11; c++) begin
            chk("nogap_playing", 32'(playing[1]),
                32'(((c >= s + 2) && (c <= s + 5)) || ((c >= s + 7) && (c <= s + 10))));
            chk("nogap_busy", 32'(busy[1]), 32'(c <= s + 10));
            tick();
        end

        tick();
        tick();
        chk("sb_drain_a", exp_a.size(), 0);
        chk("sb_drain_b", exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
